timer_prog_seq: RTL and testbench

Command sequencer that sits between the CPU-side control path and one timer device on the timer register bus (CTRL at ADD 2'b00, PRESET at 2'b01, COUNT at 2'b10).
- Turns single high-level commands (START, STOP, RELOAD, READ) into correctly ordered timer register accesses.
- Keeps a shadow copy of the timer CTRL register.
- Converts the timer's level IRQ into a sticky, acknowledgeable interrupt.

---
 rtl/timer_prog_seq.sv | 151 +++++++++++++++
 tb/tb_timer_prog_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/timer_prog_seq.sv
// Command sequencer for one timer: expands START/STOP/RELOAD/READ into ordered
// register-bus accesses, shadows CTRL and turns the timer level IRQ into a sticky one.
module timer_prog_seq #(
    parameter int DW = 32
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          CMD_VLD,
    output logic          CMD_RDY,
    input  logic [1:0]    CMD_OP,
    input  logic [DW-1:0] CMD_VAL,
    input  logic [2:0]    CMD_CFG,
    output logic          RSP_VLD,
    output logic [DW-1:0] RSP_DAT,
    output logic [1:0]    ADD_O,
    output logic          WE_O,
    output logic [DW-1:0] DAT_O,
    input  logic [DW-1:0] DAT_I,
    input  logic          IRQ_I,
    input  logic          IRQ_ACK,
    output logic          IRQ_O
);

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RELOAD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [1:0] A_CTRL   = 2'b00;
    localparam logic [1:0] A_PRESET = 2'b01;
    localparam logic [1:0] A_COUNT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_STOP, WR_PRESET, WR_CTRL, WR_COUNT, RD_COUNT, RSP
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] val_q;
    logic [2:0]    cfg_q;
    logic [3:0]    shadow, sh_nxt;
    logic          we_q, we_nxt;
    logic [1:0]    add_q, add_nxt;
    logic [DW-1:0] dat_q, dat_nxt;
    logic          rsp_vld_q, rsp_nxt;
    logic [DW-1:0] rsp_dat_q;
    logic          irq_d, irq_pend;
    logic          accept, start_acc, rise;

    assign CMD_RDY   = RST_I && (state == IDLE);
    assign accept    = CMD_VLD && CMD_RDY;
    assign start_acc = accept && (CMD_OP == OP_START);
    assign rise      = IRQ_I && !irq_d;

    // Bus outputs are computed for the state being entered, then registered,
    // so each write state drives exactly one cycle of WE_O.
    always_comb begin
        state_nxt = state;
        sh_nxt    = shadow;
        we_nxt    = 1'b0;
        add_nxt   = A_CTRL;
        dat_nxt   = '0;
        rsp_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (CMD_OP)
                        OP_START: begin
                            state_nxt = WR_STOP;
                            we_nxt    = 1'b1;
                            dat_nxt   = {{(DW-4){1'b0}}, shadow[3:1], 1'b0};
                        end
                        OP_STOP: begin
                            state_nxt = WR_CTRL;
                            we_nxt    = 1'b1;
                            dat_nxt   = {{(DW-4){1'b0}}, shadow[3:1], 1'b0};
                            sh_nxt[0] = 1'b0;
                        end
                        OP_RELOAD: begin
                            state_nxt = WR_COUNT;
                            we_nxt    = 1'b1;
                            add_nxt   = A_COUNT;
                            dat_nxt   = CMD_VAL;
                        end
                        default: begin
                            state_nxt = RD_COUNT;
                            add_nxt   = A_COUNT;
                        end
                    endcase
                end
            end
            WR_STOP: begin
                state_nxt = WR_PRESET;
                we_nxt    = 1'b1;
                add_nxt   = A_PRESET;
                dat_nxt   = val_q;
            end
            WR_PRESET: begin
                state_nxt = WR_CTRL;
                we_nxt    = 1'b1;
                dat_nxt   = {{(DW-4){1'b0}}, cfg_q, 1'b1};
                sh_nxt    = {cfg_q, 1'b1};
            end
            WR_CTRL, WR_COUNT, RD_COUNT: begin
                state_nxt = RSP;
                rsp_nxt   = 1'b1;
            end
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            val_q     <= '0;
            cfg_q     <= '0;
            shadow    <= '0;
            we_q      <= 1'b0;
            add_q     <= A_CTRL;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            irq_d     <= 1'b0;
            irq_pend  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= sh_nxt;
            we_q      <= we_nxt;
            add_q     <= add_nxt;
            dat_q     <= dat_nxt;
            rsp_vld_q <= rsp_nxt;
            irq_d     <= IRQ_I;
            // a fresh rise beats a simultaneous ACK or START clear
            irq_pend  <= rise || (irq_pend && !IRQ_ACK && !start_acc);
            if (accept) begin
                val_q <= CMD_VAL;
                cfg_q <= CMD_CFG;
            end
            if (rsp_nxt)
                rsp_dat_q <= (state == RD_COUNT) ? DAT_I : '0;
        end
    end

    assign WE_O    = we_q;
    assign ADD_O   = add_q;
    assign DAT_O   = dat_q;
    assign RSP_VLD = rsp_vld_q;
    assign RSP_DAT = rsp_dat_q;
    assign IRQ_O   = irq_pend;

endmodule

// File: tb/tb_timer_prog_seq.sv
// Directed bench for timer_prog_seq: expected bus beats and responses are queued
// at command issue and popped as the sequencer produces them.
module tb_timer_prog_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, cmd_vld, cmd_rdy, rsp_vld, we_o, irq_i, irq_ack, irq_o;
    logic [1:0]    cmd_op, add_o;
    logic [DW-1:0] cmd_val, rsp_dat, dat_o, dat_i, cnt_reg;
    logic [2:0]    cmd_cfg;

    always #5 clk = ~clk;

    assign dat_i = (add_o == 2'b10) ? cnt_reg : 32'hA5A5_0000;

    timer_prog_seq #(.DW(DW)) dut (
        .CLK_I(clk), .RST_I(rst_n), .CMD_VLD(cmd_vld), .CMD_RDY(cmd_rdy),
        .CMD_OP(cmd_op), .CMD_VAL(cmd_val), .CMD_CFG(cmd_cfg),
        .RSP_VLD(rsp_vld), .RSP_DAT(rsp_dat), .ADD_O(add_o), .WE_O(we_o),
        .DAT_O(dat_o), .DAT_I(dat_i), .IRQ_I(irq_i), .IRQ_ACK(irq_ack), .IRQ_O(irq_o)
    );

    typedef struct { logic [1:0] add; logic [DW-1:0] dat; } beat_t;
    beat_t         wq[$];
    logic [DW-1:0] rq[$];
    logic [3:0]    sh;
    int            n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [1:0] a, input logic [DW-1:0] d);
        beat_t b;
        b.add = a;
        b.dat = d;
        wq.push_back(b);
    endtask

    // Issue one command from IDLE and follow it to its response.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] val,
                           input logic [2:0] cfg, input string tag);
        int    lat;
        beat_t e;
        chk({tag, ":rdy_before"}, cmd_rdy, 1);
        case (op)
            2'b00: begin
                push_w(2'b00, {28'b0, sh[3:1], 1'b0});
                push_w(2'b01, val);
                push_w(2'b00, {28'b0, cfg, 1'b1});
                sh  = {cfg, 1'b1};
                lat = 4;
                rq.push_back('0);
            end
            2'b01: begin
                push_w(2'b00, {28'b0, sh[3:1], 1'b0});
                sh[0] = 1'b0;
                lat   = 2;
                rq.push_back('0);
            end
            2'b10: begin
                push_w(2'b10, val);
                lat = 2;
                rq.push_back('0);
            end
            default: begin
                lat = 2;
                rq.push_back(cnt_reg);
            end
        endcase
        cmd_vld = 1'b1; cmd_op = op; cmd_val = val; cmd_cfg = cfg;
        tick();
        cmd_vld = 1'b0; cmd_op = ~op; cmd_val = '1; cmd_cfg = 3'b011;
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                chk({tag, ":we"}, we_o, (op != 2'b11));
                chk({tag, ":rsp_early"}, rsp_vld, 0);
                if (op == 2'b11) begin
                    chk({tag, ":rd_add"}, add_o, 2'b10);
                    chk({tag, ":rd_dat0"}, dat_o, 0);
                end else if (we_o && wq.size() > 0) begin
                    e = wq.pop_front();
                    chk({tag, ":add"}, add_o, e.add);
                    chk({tag, ":dat"}, dat_o, e.dat);
                end
            end else begin
                chk({tag, ":rsp_vld"}, rsp_vld, 1);
                chk({tag, ":rdy_rsp"}, cmd_rdy, 0);
                chk({tag, ":we_rsp"}, we_o, 0);
                chk({tag, ":dat_rsp"}, dat_o, 0);
                chk({tag, ":rsp_dat"}, rsp_dat, (rq.size() > 0) ? rq.pop_front() : 32'hDEAD_BEEF);
            end
            tick();
        end
        chk({tag, ":beats_left"}, wq.size(), 0);
        chk({tag, ":rsp_one"}, rsp_vld, 0);
        chk({tag, ":rdy_after"}, cmd_rdy, 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_val = '0; cmd_cfg = '0;
        irq_i = 1'b0; irq_ack = 1'b0; cnt_reg = '0; sh = '0;
        tick(); tick();
        chk("rst:we", we_o, 0);
        chk("rst:add", add_o, 0);
        chk("rst:dat", dat_o, 0);
        chk("rst:rsp_vld", rsp_vld, 0);
        chk("rst:rsp_dat", rsp_dat, 0);
        chk("rst:irq", irq_o, 0);
        chk("rst:rdy", cmd_rdy, 0);
        rst_n = 1'b1;
        tick();

        run_cmd(2'b00, 32'd5, 3'b100, "start1");
        run_cmd(2'b01, 32'd0, 3'b000, "stop1");
        run_cmd(2'b00, 32'd7, 3'b100, "start2");
        cnt_reg = 32'h1234;
        run_cmd(2'b11, 32'd0, 3'b000, "read");
        tick();
        chk("read:rsp_hold", rsp_dat, 32'h1234);
        run_cmd(2'b10, 32'hFF, 3'b000, "reload");
        run_cmd(2'b01, 32'd0, 3'b000, "stop2");

        // interrupt: level held high sets pending once
        irq_i = 1'b1;
        tick();
        chk("irq:set", irq_o, 1);
        tick(); tick();
        chk("irq:sticky", irq_o, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("irq:ack", irq_o, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("irq:level_no_reset", irq_o, 0);
        end
        irq_i = 1'b0;
        tick();
        irq_i = 1'b1; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("irq:set_wins_ack", irq_o, 1);
        run_cmd(2'b00, 32'd3, 3'b010, "start_clr");
        chk("irq:start_clears", irq_o, 0);

        // reset in the middle of a START
        irq_i = 1'b0;
        tick();
        cmd_vld = 1'b1; cmd_op = 2'b00; cmd_val = 32'h55; cmd_cfg = 3'b111;
        tick();
        cmd_vld = 1'b0;
        chk("mid:t1_we", we_o, 1);
        irq_i = 1'b1;
        tick();
        chk("mid:t2_add", add_o, 2'b01);
        chk("mid:t2_dat", dat_o, 32'h55);
        chk("mid:t2_irq", irq_o, 1);
        rst_n = 1'b0; irq_i = 1'b0;
        tick();
        sh = '0;
        chk("mid:we", we_o, 0);
        chk("mid:dat", dat_o, 0);
        chk("mid:rsp", rsp_vld, 0);
        chk("mid:irq", irq_o, 0);
        chk("mid:rdy", cmd_rdy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mid:no_we", we_o, 0);
            chk("mid:no_rsp", rsp_vld, 0);
            tick();
        end
        run_cmd(2'b01, 32'd0, 3'b000, "stop_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
